// File: rtl/phase_timer.sv
// Phase interval timer for the traffic-light controller: counts a short or long interval and returns a one-cycle counter_done pulse.
// Optional macro PHASE_TIMER_REMAIN_EN adds the 'remaining' countdown output.
module phase_timer #(
    parameter int unsigned SHORT_COUNT = 15,
    parameter int unsigned LONG_COUNT  = 63,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             short_counter,
    input  logic             long_counter,
    input  logic             hold,
    input  logic             abort,
    output logic             counter_done,
    output logic             busy,
    output logic             conflict
`ifdef PHASE_TIMER_REMAIN_EN
    ,
    output logic [CNT_W-1:0] remaining
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_COUNT - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_COUNT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conflict_q, conflict_d;
    logic             counter_done_q, counter_done_d;
    logic             busy_q, busy_d;
`ifdef PHASE_TIMER_REMAIN_EN
    logic [CNT_W-1:0] remaining_q, remaining_d;
`endif

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            conflict_q     <= 1'b0;
            counter_done_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef PHASE_TIMER_REMAIN_EN
            remaining_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            conflict_q     <= conflict_d;
            counter_done_q <= counter_done_d;
            busy_q         <= busy_d;
`ifdef PHASE_TIMER_REMAIN_EN
            remaining_q    <= remaining_d;
`endif
        end
    end

    // Next state; outputs are decoded from the next state so they register in step with it
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = conflict_q;

        case (state_q)
            IDLE: begin
                if (long_counter) begin
                    cnt_d   = LONG_LOAD;
                    state_d = RUN;
                    if (short_counter) begin
                        conflict_d = 1'b1;
                    end
                end else if (short_counter) begin
                    cnt_d   = SHORT_LOAD;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hold) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        counter_done_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
`ifdef PHASE_TIMER_REMAIN_EN
        remaining_d    = (state_d == RUN) ? cnt_d : '0;
`endif
    end

    assign counter_done = counter_done_q;
    assign busy         = busy_q;
    assign conflict     = conflict_q;
`ifdef PHASE_TIMER_REMAIN_EN
    assign remaining    = remaining_q;
`endif

endmodule
